urv_muldiv_iter: RTL
====================

URV_MULDIV_ITER -- requirements
Module: urv_muldiv_iter

Interface
REQ-001 SHALL have parameter g_width, default 32, operand/result width (8..64).
REQ-002 SHALL have parameter g_with_mulh, default 1; 0 disables MULH/MULHSU/MULHU.
REQ-003 SHALL have port clk_i  in  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port rst_n_i  in  1  reset; synchronous, active-low.
REQ-005 SHALL have port x_stall_i  in  1  pipeline stall from the rest of the core.
REQ-006 SHALL have port x_kill_i  in  1  abort the current instruction.
REQ-007 SHALL have port d_valid_i  in  1  the decode-stage instruction is valid.
REQ-008 SHALL have port d_is_multiply_i  in  1  MUL-class instruction.
REQ-009 SHALL have port d_is_divide_i  in  1  DIV/REM-class instruction.
REQ-010 SHALL have port d_fun_i  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-011 SHALL have port d_rs1_i  in  g_width  dividend / multiplicand.
REQ-012 SHALL have port d_rs2_i  in  g_width  divisor / multiplier.
REQ-013 SHALL have port x_stall_req_o  out  1  combinational stall request to the pipeline.
REQ-014 SHALL have port x_rd_o  out  g_width  registered result.
REQ-015 SHALL have port x_rd_valid_o  out  1  x_rd_o holds a valid result (DONE state).
REQ-016 SHALL have port busy_o  out  1  state is not IDLE.

Function
REQ-017 SHALL implement the FSM states IDLE, ITER, FIX and DONE.
REQ-018 Start condition: IDLE & d_valid_i & (d_is_multiply_i | d_is_divide_i) & !x_kill_i; x_stall_i does not block a start.
REQ-019 On start (cycle 0), SHALL capture the operand magnitudes, the result-sign flags, the op and an iteration counter = g_width, then enter ITER.
REQ-020 Operand signedness: rs1 is signed for MULH, MULHSU, DIV and REM; rs2 is signed for MULH, DIV and REM; all other cases unsigned.
REQ-021 In ITER, multiply SHALL be shift-add at 1 bit per cycle into a 2*g_width accumulator.
REQ-022 In ITER, divide SHALL be restoring division at 1 bit per cycle, producing quotient and remainder.
REQ-023 Counter SHALL decrement once per ITER cycle; at 1 the FSM moves to FIX, so ITER occupies cycles 1..g_width.
REQ-024 FIX (cycle g_width+1) SHALL apply two's-complement sign correction and select the output:
  - low half: MUL
  - high half: MULH*
  - quotient: DIV*
  - remainder: REM*
  It SHALL register x_rd_o, then enter DONE.
REQ-025 Remainder sign SHALL equal the dividend sign; quotient SHALL truncate toward zero.
REQ-026 Divide by zero SHALL bypass ITER and enter DONE at cycle 1 with:
  - quotient = all ones
  - remainder = rs1
REQ-027 Signed overflow (rs1 = most negative, rs2 = -1, DIV/REM) SHALL bypass ITER with:
  - quotient = rs1
  - remainder = 0
  - DONE at cycle 1.
REQ-028 With g_with_mulh=0, funct3 001..011 SHALL return 0 with DONE at cycle 1.
REQ-029 x_stall_req_o SHALL be 1 in the start cycle and in every ITER/FIX cycle, and 0 in DONE and otherwise.
REQ-030 DONE SHALL assert x_rd_valid_o=1 and hold x_rd_o stable while x_stall_i=1.
REQ-031 DONE with x_stall_i=0 SHALL go to IDLE next cycle; no restart of the same instruction is allowed in that DONE cycle.
REQ-032 x_kill_i=1 in any state SHALL force IDLE next cycle and take priority over start and all transitions; x_stall_req_o SHALL drop combinationally in that cycle.
REQ-033 Total multiply/normal-divide latency SHALL be g_width+2 cycles from start to DONE.
REQ-034 All arithmetic SHALL be exact for any g_width; the most negative operand SHALL be handled via a (g_width+1)-bit magnitude.

Reset
REQ-035 While rst_n_i=0 at a clock edge, the block SHALL enter IDLE with the following outputs:
  - x_rd_o = 0
  - x_rd_valid_o = 0
  - busy_o = 0
  - counter = 0
REQ-036 x_stall_req_o SHALL be 0 during reset.
REQ-037 Reset mid-operation SHALL abandon the operation with no result.

Verification (g_width=32)
REQ-038 MUL rs1=0xFFFFFFFF, rs2=0x00000003 -> DONE at cycle 34, x_rd_o=0xFFFFFFFD; MULHU same operands -> 0x00000002; MULH -> 0xFFFFFFFF.
REQ-039 DIV rs1=-7 (0xFFFFFFF9), rs2=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU rs1=100, rs2=7 -> 14, REMU -> 2.
REQ-040 DIV rs2=0, rs1=0x1234 -> 0xFFFFFFFF at cycle 1; REM -> 0x1234; DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
REQ-041 Start a DIV, assert x_kill_i at cycle 10 -> busy_o=0 and x_stall_req_o=0 next cycle; a new MUL 6*7 then returns 42.
REQ-042 In DONE, hold x_stall_i=1 for 5 cycles -> x_rd_valid_o=1, result stable, no restart; release -> IDLE next cycle.
REQ-043 rst_n_i=0 at cycle 15 of a MULH -> all outputs 0 next cycle; g_width=16 build: MUL 0xFFFF*0xFFFF -> 0x0001 at cycle 18.

Source files
------------

// File: rtl/urv_muldiv_iter.sv
// -----------------------------------------------------------------------------
// urv_muldiv_iter
//
// Iterative RV32M multiply / divide unit. It retires one result bit per cycle:
// shift-add for the MUL class and restoring division for DIV/REM. The work is
// done on operand magnitudes, and the sign is fixed up in a final cycle.
// Divide-by-zero, signed overflow and the disabled MULH* encodings skip the
// iteration and report their architectural result one cycle after start.
//
// Ports
//   clk_i            : clock, all logic on the rising edge
//   rst_n_i          : synchronous active-low reset
//   x_stall_i        : pipeline stall; holds the DONE state and its result
//   x_kill_i         : abort the current instruction (IDLE next cycle)
//   d_valid_i        : decode-stage instruction valid
//   d_is_multiply_i  : MUL-class instruction
//   d_is_divide_i    : DIV/REM-class instruction
//   d_fun_i          : RV32M funct3
//   d_rs1_i          : dividend / multiplicand
//   d_rs2_i          : divisor / multiplier
//   x_stall_req_o    : combinational stall request to the pipeline
//   x_rd_o           : registered result
//   x_rd_valid_o     : x_rd_o is valid (DONE state)
//   busy_o           : unit is not IDLE
// -----------------------------------------------------------------------------
module urv_muldiv_iter #(
  parameter int g_width     = 32,
  parameter int g_with_mulh = 1
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               x_stall_i,
  input  logic               x_kill_i,
  input  logic               d_valid_i,
  input  logic               d_is_multiply_i,
  input  logic               d_is_divide_i,
  input  logic [2:0]         d_fun_i,
  input  logic [g_width-1:0] d_rs1_i,
  input  logic [g_width-1:0] d_rs2_i,
  output logic               x_stall_req_o,
  output logic [g_width-1:0] x_rd_o,
  output logic               x_rd_valid_o,
  output logic               busy_o
);

  localparam int c_cnt_w = $clog2(g_width + 1);
  localparam logic [g_width-1:0] c_most_neg = {1'b1, {(g_width-1){1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_FIX, ST_DONE} state_t;

  state_t r_state;
  state_t w_state_next;

  // Datapath registers. r_acc holds {hi, lo}: for multiply the partial
  // product / remaining multiplier, for divide the partial remainder /
  // dividend being shifted out while quotient bits are shifted in.
  logic [2*g_width-1:0] r_acc;
  logic [g_width:0]     r_b;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [g_width-1:0]   r_rd;
  logic                 r_is_div;
  logic [1:0]           r_fun;
  logic                 r_neg_res;
  logic                 r_neg_rem;

  // ---------------------------------------------------------------------------
  // Start-cycle decode
  // ---------------------------------------------------------------------------
  logic               w_start;
  logic               w_is_div;
  logic               w_rs1_signed;
  logic               w_rs2_signed;
  logic               w_rs1_neg;
  logic               w_rs2_neg;
  logic [g_width:0]   w_rs1_ext;
  logic [g_width:0]   w_rs2_ext;
  logic [g_width:0]   w_rs1_mag;
  logic [g_width:0]   w_rs2_mag;
  logic               w_div_zero;
  logic               w_div_ovf;
  logic               w_mulh_off;
  logic               w_bypass;
  logic [g_width-1:0] w_bypass_rd;

  assign w_start  = (r_state == ST_IDLE) & d_valid_i &
                    (d_is_multiply_i | d_is_divide_i) & ~x_kill_i;
  assign w_is_div = d_is_divide_i;

  assign w_rs1_signed = w_is_div ? ~d_fun_i[0] : ((d_fun_i == 3'b001) || (d_fun_i == 3'b010));
  assign w_rs2_signed = w_is_div ? ~d_fun_i[0] : (d_fun_i == 3'b001);

  assign w_rs1_neg = w_rs1_signed & d_rs1_i[g_width-1];
  assign w_rs2_neg = w_rs2_signed & d_rs2_i[g_width-1];

  // One extra bit so the magnitude of the most negative value is exact.
  assign w_rs1_ext = {w_rs1_neg, d_rs1_i};
  assign w_rs2_ext = {w_rs2_neg, d_rs2_i};
  assign w_rs1_mag = w_rs1_neg ? -w_rs1_ext : w_rs1_ext;
  assign w_rs2_mag = w_rs2_neg ? -w_rs2_ext : w_rs2_ext;

  assign w_div_zero = w_is_div & (d_rs2_i == '0);
  assign w_div_ovf  = w_is_div & ~d_fun_i[0] & (d_rs1_i == c_most_neg) & (d_rs2_i == '1);
  assign w_mulh_off = ~w_is_div & (g_with_mulh == 0) & (d_fun_i[1:0] != 2'b00);
  assign w_bypass   = w_div_zero | w_div_ovf | w_mulh_off;

  always_comb begin
    w_bypass_rd = '0;
    if (w_div_zero) begin
      w_bypass_rd = d_fun_i[1] ? d_rs1_i : '1;
    end else if (w_div_ovf) begin
      w_bypass_rd = d_fun_i[1] ? '0 : d_rs1_i;
    end
  end

  // ---------------------------------------------------------------------------
  // One iteration step
  // ---------------------------------------------------------------------------
  logic [g_width:0]     w_mul_sum;
  logic [2*g_width-1:0] w_mul_next;
  logic [g_width:0]     w_div_shift;
  logic                 w_div_ge;
  logic [g_width-1:0]   w_div_diff;
  logic [2*g_width-1:0] w_div_next;

  // Shift-add: add the multiplicand into the high half when the current
  // multiplier LSB is set, then shift the whole accumulator right.
  assign w_mul_sum  = {1'b0, r_acc[2*g_width-1:g_width]} + (r_acc[0] ? r_b : '0);
  assign w_mul_next = {w_mul_sum, r_acc[g_width-1:1]};

  // Restoring division: bring in the next dividend bit, subtract when it fits.
  // A kept difference is always below the divisor, so W bits suffice for it.
  assign w_div_shift = {r_acc[2*g_width-1:g_width], r_acc[g_width-1]};
  assign w_div_ge    = (w_div_shift >= r_b);
  assign w_div_diff  = w_div_shift[g_width-1:0] - r_b[g_width-1:0];
  assign w_div_next  = {(w_div_ge ? w_div_diff : w_div_shift[g_width-1:0]),
                        r_acc[g_width-2:0], w_div_ge};

  // ---------------------------------------------------------------------------
  // Sign correction and result select
  // ---------------------------------------------------------------------------
  logic [2*g_width-1:0] w_prod;
  logic [g_width-1:0]   w_quo;
  logic [g_width-1:0]   w_rem;
  logic [g_width-1:0]   w_fix_rd;

  assign w_prod = r_neg_res ? -r_acc : r_acc;
  assign w_quo  = r_neg_res ? -r_acc[g_width-1:0] : r_acc[g_width-1:0];
  assign w_rem  = r_neg_rem ? -r_acc[2*g_width-1:g_width] : r_acc[2*g_width-1:g_width];

  always_comb begin
    w_fix_rd = '0;
    if (r_is_div) begin
      w_fix_rd = r_fun[1] ? w_rem : w_quo;
    end else if (r_fun == 2'b00) begin
      w_fix_rd = w_prod[g_width-1:0];
    end else begin
      w_fix_rd = w_prod[2*g_width-1:g_width];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state (kill overrides everything)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    if (x_kill_i) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_start) w_state_next = w_bypass ? ST_DONE : ST_ITER;
        ST_ITER: if (r_cnt == c_cnt_w'(1)) w_state_next = ST_FIX;
        ST_FIX:  w_state_next = ST_DONE;
        ST_DONE: if (!x_stall_i) w_state_next = ST_IDLE;
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    x_stall_req_o = 1'b0;
    busy_o        = (r_state != ST_IDLE);
    x_rd_valid_o  = (r_state == ST_DONE);
    if (rst_n_i && !x_kill_i) begin
      case (r_state)
        ST_IDLE: x_stall_req_o = w_start;
        ST_ITER: x_stall_req_o = 1'b1;
        ST_FIX:  x_stall_req_o = 1'b1;
        default: x_stall_req_o = 1'b0;
      endcase
    end
  end

  assign x_rd_o = r_rd;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_acc     <= '0;
      r_b       <= '0;
      r_cnt     <= '0;
      r_rd      <= '0;
      r_is_div  <= 1'b0;
      r_fun     <= 2'b00;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
    end else if (w_start) begin
      r_is_div  <= w_is_div;
      r_fun     <= d_fun_i[1:0];
      r_neg_res <= w_rs1_neg ^ w_rs2_neg;
      r_neg_rem <= w_rs1_neg;
      r_cnt     <= c_cnt_w'(g_width);
      if (w_is_div) begin
        r_acc <= {{g_width{1'b0}}, w_rs1_mag[g_width-1:0]};
        r_b   <= w_rs2_mag;
      end else begin
        r_acc <= {{g_width{1'b0}}, w_rs2_mag[g_width-1:0]};
        r_b   <= w_rs1_mag;
      end
      if (w_bypass) begin
        r_rd <= w_bypass_rd;
      end
    end else if (!x_kill_i) begin
      if (r_state == ST_ITER) begin
        r_acc <= r_is_div ? w_div_next : w_mul_next;
        r_cnt <= r_cnt - c_cnt_w'(1);
      end else if (r_state == ST_FIX) begin
        r_rd <= w_fix_rd;
      end
    end
  end

endmodule
